// File: rtl/cfg_pkg.sv
// Shared definitions for the CRAM configuration loader: loader state
// encoding and the default chain geometry / settle timing.
package cfg_pkg;

    // Default chain length: one LE = 16 LUT bits + 4 mode bits
    localparam int CFG_CHAIN_LEN  = 20;

    // Default host word width in bits
    localparam int CFG_WORD_W     = 8;

    // Default cycles the fabric is held in reset after the last shifted bit
    localparam int CFG_SETTLE_CYC = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/cfg_serializer.sv
// Word datapath of the configuration loader. A parallel-in/serial-out
// register feeds the chain head MSB first, while a serial-in/parallel-out
// register collects the old chain contents returning from the tail. At the
// end of each word the collected bits are presented left-aligned (a short
// final word is zero-padded in its low bits) with a one-cycle valid pulse.
module cfg_serializer
    import cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_shift,
    input  logic              i_last,
    input  logic              i_flush,
    input  logic              i_ret,
    output logic              o_bit,
    output logic              o_wordLast,
    output logic              o_rbValid,
    output logic [WORD_W-1:0] o_rbData
);

    localparam int BCNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_piso;
    logic [WORD_W-1:0] r_sipo;
    logic [BCNT_W-1:0] r_bitCnt;
    logic              r_rbValid;
    logic [WORD_W-1:0] r_rbData;

    logic [WORD_W:0]   w_sipoExt;
    logic [WORD_W-1:0] w_sipoNext;
    logic [BCNT_W-1:0] w_padShift;

    assign w_sipoExt  = {r_sipo, i_ret};
    assign w_sipoNext = w_sipoExt[WORD_W-1:0];
    assign w_padShift = BCNT_W'(WORD_W - 1) - r_bitCnt;

    assign o_bit      = r_piso[WORD_W-1];
    assign o_wordLast = (r_bitCnt == BCNT_W'(WORD_W - 1));
    assign o_rbValid  = r_rbValid;
    assign o_rbData   = r_rbData;

    // Outgoing word: capture on handshake, then present one bit per shift cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_piso <= '0;
        end else if (i_load) begin
            r_piso <= i_data;
        end else if (i_shift) begin
            r_piso <= r_piso << 1;
        end
    end

    // Per-word bit count and returning-bit collector, restarted for every word
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_bitCnt <= '0;
            r_sipo   <= '0;
        end else if (i_load || i_flush) begin
            r_bitCnt <= '0;
            r_sipo   <= '0;
        end else if (i_shift) begin
            r_bitCnt <= r_bitCnt + BCNT_W'(1);
            r_sipo   <= w_sipoNext;
        end
    end

    // Publish the returned bits one cycle after the last bit of the word
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rbValid <= 1'b0;
            r_rbData  <= '0;
        end else begin
            r_rbValid <= 1'b0;
            if (i_shift && i_last && !i_flush) begin
                r_rbValid <= 1'b1;
                r_rbData  <= w_sipoNext << w_padShift;
            end
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// CRAM scan-chain configuration loader. Accepts host words, shifts them
// MSB first into the LE configuration chain, returns the previous chain
// contents as readback words, then holds the fabric in reset for a fixed
// settle time before releasing it and flagging done.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN  = CFG_CHAIN_LEN,
    parameter int WORD_W     = CFG_WORD_W,
    parameter int SETTLE_CYC = CFG_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              cfg_en,
    output logic              cfg_data,
    input  logic              cfg_ret,
    output logic              fabric_nrst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    cfg_state_t       r_state;
    logic [CNT_W-1:0] r_chainCnt;
    logic [SET_W-1:0] r_settleCnt;
    logic             r_sReady;
    logic             r_cfgEn;
    logic             r_fabricNrst;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic w_accept;
    logic w_abortHit;
    logic w_chainLast;
    logic w_wordLast;
    logic w_lastBit;
    logic w_headBit;

    // Abort only matters while a load is running, and it beats a handshake
    assign w_abortHit  = abort && r_busy;
    assign w_accept    = r_sReady && s_valid && !abort;
    assign w_chainLast = (r_chainCnt == CNT_W'(CHAIN_LEN - 1));
    assign w_lastBit   = r_cfgEn && !abort && (w_wordLast || w_chainLast);

    assign s_ready     = r_sReady;
    assign cfg_en      = r_cfgEn;
    assign cfg_data    = w_headBit & r_cfgEn;
    assign fabric_nrst = r_fabricNrst;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

    cfg_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk        (clk),
        .nrst       (nrst),
        .i_load     (w_accept),
        .i_data     (s_data),
        .i_shift    (r_cfgEn),
        .i_last     (w_lastBit),
        .i_flush    (w_abortHit),
        .i_ret      (cfg_ret),
        .o_bit      (w_headBit),
        .o_wordLast (w_wordLast),
        .o_rbValid  (rb_valid),
        .o_rbData   (rb_data)
    );

    // Load sequencer with registered handshake, shift-enable and status outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_chainCnt   <= '0;
            r_settleCnt  <= '0;
            r_sReady     <= 1'b0;
            r_cfgEn      <= 1'b0;
            r_fabricNrst <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else if (w_abortHit) begin
            r_state  <= ST_IDLE;
            r_sReady <= 1'b0;
            r_cfgEn  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        r_state      <= ST_LOAD;
                        r_chainCnt   <= '0;
                        r_sReady     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_fabricNrst <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        r_state  <= ST_SHIFT;
                        r_sReady <= 1'b0;
                        r_cfgEn  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_chainCnt <= r_chainCnt + CNT_W'(1);
                    if (w_chainLast) begin
                        r_state     <= ST_SETTLE;
                        r_cfgEn     <= 1'b0;
                        r_settleCnt <= '0;
                    end else if (w_wordLast) begin
                        r_state  <= ST_LOAD;
                        r_cfgEn  <= 1'b0;
                        r_sReady <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_settleCnt == SET_W'(SETTLE_CYC - 1)) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_fabricNrst <= 1'b1;
                    end else begin
                        r_settleCnt <= r_settleCnt + SET_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader with a 20-bit behavioural CRAM chain
// attached between cfg_data/cfg_en and cfg_ret.
module tb_cfg_loader;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       cfg_en;
    logic       cfg_data;
    logic       cfg_ret;
    logic       fabric_nrst;
    logic       busy;
    logic       done;
    logic       err;
    logic       rb_valid;
    logic [7:0] rb_data;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [19:0] chain = 20'h12345;
    logic [31:0] shiftLog;
    int          shiftCount;
    int          settleCount;
    logic [7:0]  rbLog [0:3];
    int          rbCount;
    logic        logClear = 1'b0;
    int          gapEn;

    cfg_loader #(
        .CHAIN_LEN  (20),
        .WORD_W     (8),
        .SETTLE_CYC (4)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .abort       (abort),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .cfg_en      (cfg_en),
        .cfg_data    (cfg_data),
        .cfg_ret     (cfg_ret),
        .fabric_nrst (fabric_nrst),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rb_valid    (rb_valid),
        .rb_data     (rb_data)
    );

    always #5 clk = ~clk;

    assign cfg_ret = chain[19];

    // Behavioural CRAM chain: shifts toward the tail whenever cfg_en is high
    always @(posedge clk) begin
        if (cfg_en) chain <= {chain[18:0], cfg_data};
    end

    // Observation log: shifted bits, settle cycles and readback words
    always @(posedge clk) begin
        if (logClear) begin
            shiftLog    <= '0;
            shiftCount  <= 0;
            settleCount <= 0;
            rbCount     <= 0;
        end else begin
            if (cfg_en) begin
                shiftLog   <= {shiftLog[30:0], cfg_data};
                shiftCount <= shiftCount + 1;
            end
            if (busy && !s_ready && !cfg_en) settleCount <= settleCount + 1;
            if (rb_valid) begin
                if (rbCount < 4) rbLog[rbCount] <= rb_data;
                rbCount <= rbCount + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string prefix);
        checkOutput({prefix, "_s_ready"},     32'(s_ready),     32'd0);
        checkOutput({prefix, "_cfg_en"},      32'(cfg_en),      32'd0);
        checkOutput({prefix, "_cfg_data"},    32'(cfg_data),    32'd0);
        checkOutput({prefix, "_fabric_nrst"}, 32'(fabric_nrst), 32'd0);
        checkOutput({prefix, "_busy"},        32'(busy),        32'd0);
        checkOutput({prefix, "_done"},        32'(done),        32'd0);
        checkOutput({prefix, "_err"},         32'(err),         32'd0);
        checkOutput({prefix, "_rb_valid"},    32'(rb_valid),    32'd0);
        checkOutput({prefix, "_rb_data"},     32'(rb_data),     32'd0);
    endtask

    task automatic clearLog();
        logClear = 1'b1;
        @(negedge clk);
        logClear = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one word, wait for the handshake, return in the first shift cycle
    task automatic applyStimulus(input logic [7:0] word);
        int n;
        s_valid = 1'b1;
        s_data  = word;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checkOutput("readyTimeout", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
        end else begin
            @(negedge clk);
            s_valid = 1'b0;
            checkOutput("firstBitLatency", 32'(cfg_en), 32'd1);
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneReached", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nrst    = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Load 1: A5 3C F0 over an initial chain of 0x12345
        clearLog();
        pulseStart();
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        applyStimulus(8'hF0);
        waitDone();
        checkOutput("load1ShiftCount", 32'(shiftCount), 32'd20);
        checkOutput("load1Bits", shiftLog & 32'h000F_FFFF, 32'h000A_53CF);
        checkOutput("load1Chain", 32'(chain), 32'h000A_53CF);
        checkOutput("load1Settle", 32'(settleCount), 32'd4);
        checkOutput("load1FabricNrst", 32'(fabric_nrst), 32'd1);
        checkOutput("load1Busy", 32'(busy), 32'd0);
        checkOutput("load1RbCount", 32'(rbCount), 32'd3);
        checkOutput("load1Rb0", 32'(rbLog[0]), 32'h12);
        checkOutput("load1Rb1", 32'(rbLog[1]), 32'h34);
        checkOutput("load1Rb2", 32'(rbLog[2]), 32'h50);
        repeat (3) @(negedge clk);
        checkOutput("doneHeld", 32'(done), 32'd1);

        // Load 2: zeros, readback must return load 1 contents
        clearLog();
        pulseStart();
        checkOutput("doneClearedByStart", 32'(done), 32'd0);
        applyStimulus(8'h00);
        repeat (7) @(negedge clk);
        checkOutput("rbValidEarly", 32'(rb_valid), 32'd0);
        @(negedge clk);
        checkOutput("rbValidPulse", 32'(rb_valid), 32'd1);
        checkOutput("rbDataPulse", 32'(rb_data), 32'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        waitDone();
        checkOutput("load2RbCount", 32'(rbCount), 32'd3);
        checkOutput("load2Rb0", 32'(rbLog[0]), 32'hA5);
        checkOutput("load2Rb1", 32'(rbLog[1]), 32'h3C);
        checkOutput("load2Rb2", 32'(rbLog[2]), 32'hF0);
        checkOutput("load2Chain", 32'(chain), 32'd0);

        // Load 3: 10-cycle stall between words, with a start pulse while busy
        clearLog();
        pulseStart();
        applyStimulus(8'hA5);
        repeat (8) @(negedge clk);
        gapEn = 0;
        for (int i = 0; i < 10; i++) begin
            if (cfg_en) gapEn++;
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("gapCfgEn", 32'(gapEn), 32'd0);
        checkOutput("gapReady", 32'(s_ready), 32'd1);
        checkOutput("gapChainHeld", 32'(chain), 32'h0000_0A5);
        applyStimulus(8'h3C);
        applyStimulus(8'hF0);
        waitDone();
        checkOutput("load3ShiftCount", 32'(shiftCount), 32'd20);
        checkOutput("load3Chain", 32'(chain), 32'h000A_53CF);

        // Load 4: abort after the fifth shifted bit
        clearLog();
        pulseStart();
        applyStimulus(8'hA5);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortErr", 32'(err), 32'd1);
        checkOutput("abortFabricNrst", 32'(fabric_nrst), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortCfgEn", 32'(cfg_en), 32'd0);
        checkOutput("abortReady", 32'(s_ready), 32'd0);
        checkOutput("abortShiftCount", 32'(shiftCount), 32'd5);
        checkOutput("abortChain", 32'(chain), 32'h000A_79F4);
        checkOutput("abortRbCount", 32'(rbCount), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("errSticky", 32'(err), 32'd1);

        // Load 5: full load after abort clears err
        clearLog();
        pulseStart();
        checkOutput("errClearedByStart", 32'(err), 32'd0);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        waitDone();
        checkOutput("load5Err", 32'(err), 32'd0);
        checkOutput("load5Rb0", 32'(rbLog[0]), 32'hA7);
        checkOutput("load5Rb1", 32'(rbLog[1]), 32'h9F);
        checkOutput("load5Rb2", 32'(rbLog[2]), 32'h40);

        // start and abort together in DONE: abort wins, nothing happens
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("startAbortBusy", 32'(busy), 32'd0);
        checkOutput("startAbortDone", 32'(done), 32'd1);
        checkOutput("startAbortErr", 32'(err), 32'd0);

        // nrst pulse in the middle of a shift
        pulseStart();
        applyStimulus(8'h3C);
        @(negedge clk);
        checkOutput("preResetCfgEn", 32'(cfg_en), 32'd1);
        #2 nrst = 1'b0;
        #1 checkResetOutputs("midShiftReset");
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("postResetBusy", 32'(busy), 32'd0);
        checkOutput("postResetReady", 32'(s_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 20: total bits in the CRAM scan chain (one LE = 16 LUT bits + 4 mode bits).
REQ-002 SHALL have parameter WORD_W, default 8: host word width in bits.
REQ-003 SHALL have parameter SETTLE_CYC, default 4: cycles fabric reset is held after the last bit is shifted.
REQ-004 SHALL have port clk  input  1  system clock (all logic posedge).
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle pulse that begins a load.
REQ-007 SHALL have port abort  input  1  cancels a load in progress.
REQ-008 SHALL have port s_valid  input  1  host word valid.
REQ-009 SHALL have port s_data  input  WORD_W  host word; bit WORD_W-1 is shifted first.
REQ-010 SHALL have port s_ready  output  1  word accepted when s_valid && s_ready.
REQ-011 SHALL have port cfg_en  output  1  chain shift enable; drives config_en and en of every LE.
REQ-012 SHALL have port cfg_data  output  1  serial bit to the chain head.
REQ-013 SHALL have port cfg_ret  input  1  serial bit from the chain tail (last config_data_out).
REQ-014 SHALL have port fabric_nrst  output  1  active-low reset to LE flops (le_nrst).
REQ-015 SHALL have ports busy, done, err  output  1 each  status flags.
REQ-016 SHALL have ports rb_valid (1) and rb_data (WORD_W), both outputs, carrying readback of the old chain contents.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, SETTLE, DONE.
REQ-018 IDLE/DONE: start -> LOAD; clear bit counter, done, err.
REQ-019 LOAD: s_ready=1, cfg_en=0; on handshake, latch s_data into the shift register -> SHIFT next cycle.
REQ-020 SHIFT: cfg_en=1; cfg_data=shreg[WORD_W-1]; shreg shifts left 1; bit counter +1; cfg_ret shifts into rb shreg LSB.
REQ-021 Leave SHIFT after WORD_W bits -> LOAD, or as soon as bit counter reaches CHAIN_LEN -> SETTLE, whichever comes first; the unused low bits of the final word are discarded.
REQ-022 Word accepted in cycle N SHALL produce its first cfg_en bit in cycle N+1; one LOAD bubble per word is allowed.
REQ-023 s_valid low in LOAD SHALL stall with cfg_en=0 indefinitely; chain contents are unchanged while stalled.
REQ-024 rb_valid SHALL pulse one cycle after each word's last shifted bit; rb_data = bits returned during that word, first-returned bit in MSB; a partial final word is left-aligned and zero-padded.
REQ-025 SETTLE: cfg_en=0, fabric_nrst=0 for exactly SETTLE_CYC cycles -> DONE.
REQ-026 DONE: fabric_nrst=1, done=1; held until the next start.
REQ-027 fabric_nrst SHALL be 0 in every state except DONE.
REQ-028 busy=1 in LOAD, SHIFT, SETTLE; start while busy SHALL be ignored.
REQ-029 abort in LOAD/SHIFT/SETTLE SHALL go to IDLE next cycle with cfg_en=0, s_ready=0, err=1 (sticky until the next start); abort in IDLE/DONE is ignored.
REQ-030 If abort and start are asserted together, abort SHALL win.
REQ-031 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and never wrap.

Reset
REQ-032 nrst low SHALL force IDLE immediately, including mid-shift; outputs then: s_ready=0, cfg_en=0, cfg_data=0, fabric_nrst=0, busy=0, done=0, err=0, rb_valid=0, rb_data=0.

Structure
REQ-033 Package cfg_pkg SHALL hold the state enum typedef and the default CHAIN_LEN/WORD_W/SETTLE_CYC constants.
REQ-034 A sub-module cfg_serializer SHALL contain the PISO/SIPO shift registers and the per-word bit count; cfg_loader holds the FSM, chain counter and settle counter.

Verification
REQ-035 CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0xF0 -> 20 cfg_en cycles with bits 10100101 00111100 1111; low nibble 0000 of 0xF0 dropped; done after 4 SETTLE cycles.
REQ-036 Second load of 0x00, 0x00, 0x00 after REQ-035 -> rb_data 0xA5, 0x3C, 0xF0 (last padded).
REQ-037 s_valid held low for 10 cycles between words -> cfg_en low throughout the gap; final chain identical to REQ-035.
REQ-038 abort after bit 5 -> IDLE next cycle, err=1, fabric_nrst=0, done=0; a subsequent full load clears err.
REQ-039 nrst pulse mid-SHIFT -> all outputs at reset values in the same cycle; start while busy -> no effect.
